// File: rtl/sprite_overlay.sv
// sprite_overlay: final pixel-rate compositor in front of the VGA pins.
// Overlays one 16x16, 4-bit-indexed sprite with a 16-entry 12-bit palette
// onto the background stream. It is a two-stage pipeline with fixed 2-cycle
// latency for RGB, videoActive and both syncs.
//
// Stream semantics: there is no valid/ready handshake and no back-pressure.
// Every clkPixel cycle carries exactly one pixel, and videoActive qualifies it.
// The table/position write port is fire-and-forget: a strobe (wrEn or posWr)
// is consumed on the edge where it is high.
module sprite_overlay #(
  parameter logic [9:0] V_ACTIVE  = 10'd480,
  parameter logic       SYNC_IDLE = 1'b1
) (
  input  logic        clkPixel,
  input  logic        reset,
  input  logic [9:0]  hPos,
  input  logic [9:0]  vPos,
  input  logic        videoActive,
  input  logic        hsyncIn,
  input  logic        vsyncIn,
  input  logic [3:0]  redIn,
  input  logic [3:0]  greenIn,
  input  logic [3:0]  blueIn,
  input  logic        wrEn,
  input  logic [8:0]  wrAddr,
  input  logic [11:0] wrData,
  input  logic        posWr,
  input  logic [9:0]  posX,
  input  logic [9:0]  posY,
  input  logic        spriteEn,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hsyncOut,
  output logic        vsyncOut
);

  // Position double buffer: shadow is software-visible, live drives the compare
  logic [9:0] shadow_x, shadow_y, live_x, live_y;
  logic       shadow_en, live_en;
  logic       latch_now;

  // Stage-1 compare terms
  logic [10:0] dx, dy;
  logic        hit_c;
  logic [7:0]  rd_addr;

  // Storage
  logic [3:0]  bitmap [256];
  logic [11:0] palette [16];

  // Stage-1 registers
  logic [3:0]  s1_index;
  logic        s1_hit, s1_active, s1_hs, s1_vs;
  logic [11:0] s1_rgb;

  // Stage-2 selected colour
  logic [11:0] pix_c;

  assign latch_now = (vPos == V_ACTIVE) && (hPos == 10'd0);

  // Shadow position/enable: loaded by posWr at any time
  always_ff @(posedge clkPixel or posedge reset) begin
    if (reset) begin
      shadow_x  <= '0;
      shadow_y  <= '0;
      shadow_en <= 1'b0;
    end else if (posWr) begin
      shadow_x  <= posX;
      shadow_y  <= posY;
      shadow_en <= spriteEn;
    end
  end

  // Live position: copied once per frame at the first blanking line; a
  // coincident posWr is forwarded so the fresh value is not lost for a frame
  always_ff @(posedge clkPixel or posedge reset) begin
    if (reset) begin
      live_x  <= '0;
      live_y  <= '0;
      live_en <= 1'b0;
    end else if (latch_now) begin
      live_x  <= posWr ? posX     : shadow_x;
      live_y  <= posWr ? posY     : shadow_y;
      live_en <= posWr ? spriteEn : shadow_en;
    end
  end

  // 11-bit differences: the extra bit keeps hPos<liveX from aliasing into 0..15
  assign dx      = {1'b0, hPos} - {1'b0, live_x};
  assign dy      = {1'b0, vPos} - {1'b0, live_y};
  assign hit_c   = videoActive && live_en &&
                   (hPos >= live_x) && (dx < 11'd16) &&
                   (vPos >= live_y) && (dy < 11'd16);
  assign rd_addr = {dy[3:0], dx[3:0]};

  // Bitmap RAM: one write port, one registered read port (read-old-on-collision)
  always_ff @(posedge clkPixel) begin
    if (wrEn && !wrAddr[8]) begin
      bitmap[wrAddr[7:0]] <= wrData[3:0];
    end
    s1_index <= bitmap[rd_addr];
  end

  // Palette flops: cleared on reset, written through the table port
  always_ff @(posedge clkPixel or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        palette[i] <= '0;
      end
    end else if (wrEn && wrAddr[8]) begin
      palette[wrAddr[3:0]] <= wrData;
    end
  end

  // Stage 1: register hit, background colour, active flag and syncs
  always_ff @(posedge clkPixel or posedge reset) begin
    if (reset) begin
      s1_hit    <= 1'b0;
      s1_active <= 1'b0;
      s1_rgb    <= '0;
      s1_hs     <= SYNC_IDLE;
      s1_vs     <= SYNC_IDLE;
    end else begin
      s1_hit    <= hit_c;
      s1_active <= videoActive;
      s1_rgb    <= {redIn, greenIn, blueIn};
      s1_hs     <= hsyncIn;
      s1_vs     <= vsyncIn;
    end
  end

  // Stage-2 select: blank outside the active area, index 0 is transparent
  always_comb begin
    pix_c = s1_rgb;
    if (!s1_active) begin
      pix_c = '0;
    end else if (s1_hit && (s1_index != 4'd0)) begin
      pix_c = palette[s1_index];
    end
  end

  // Stage 2: output registers driving the pins
  always_ff @(posedge clkPixel or posedge reset) begin
    if (reset) begin
      red      <= '0;
      green    <= '0;
      blue     <= '0;
      hsyncOut <= SYNC_IDLE;
      vsyncOut <= SYNC_IDLE;
    end else begin
      red      <= pix_c[11:8];
      green    <= pix_c[7:4];
      blue     <= pix_c[3:0];
      hsyncOut <= s1_hs;
      vsyncOut <= s1_vs;
    end
  end

endmodule

// File: tb/tb_sprite_overlay.sv
// tb_sprite_overlay: raster-driven bench for sprite_overlay. A reduced raster
// (selected lines/columns of an 800x525 frame) is driven with random
// background colour. A reference model computes each expected pixel and pushes
// it into exp_q. A separate monitor pops and compares 2 cycles later.
module tb_sprite_overlay;

  localparam logic SYNC_IDLE = 1'b1;

  // ---------------- clock / reset ----------------
  logic        clkPixel = 1'b0;
  logic        reset = 1'b0;
  always #5 clkPixel = ~clkPixel;

  logic [9:0]  hPos = '0, vPos = '0;
  logic        videoActive = 1'b0, hsyncIn = 1'b1, vsyncIn = 1'b1;
  logic [3:0]  redIn = '0, greenIn = '0, blueIn = '0;
  logic        wrEn = 1'b0;
  logic [8:0]  wrAddr = '0;
  logic [11:0] wrData = '0;
  logic        posWr = 1'b0;
  logic [9:0]  posX = '0, posY = '0;
  logic        spriteEn = 1'b0;
  logic [3:0]  red, green, blue;
  logic        hsyncOut, vsyncOut;

  sprite_overlay dut (
    .clkPixel(clkPixel), .reset(reset),
    .hPos(hPos), .vPos(vPos), .videoActive(videoActive),
    .hsyncIn(hsyncIn), .vsyncIn(vsyncIn),
    .redIn(redIn), .greenIn(greenIn), .blueIn(blueIn),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .posWr(posWr), .posX(posX), .posY(posY), .spriteEn(spriteEn),
    .red(red), .green(green), .blue(blue),
    .hsyncOut(hsyncOut), .vsyncOut(vsyncOut)
  );

  // ---------------- scoreboard state ----------------
  logic [13:0] exp_q[$];          // {hsync, vsync, r, g, b}
  int          n_vec = 0;
  int          n_err = 0;
  int          n_print = 0;
  logic        issued = 1'b0;
  logic        iss_d1 = 1'b0, iss_d2 = 1'b0;
  logic [13:0] mon_got, mon_exp;

  // ---------------- reference model state ----------------
  logic [11:0] m_pal [16];
  logic [3:0]  m_bmp [256];
  int          m_sh_x, m_sh_y, m_lv_x, m_lv_y;
  bit          m_sh_en, m_lv_en;
  int          lines[$];
  int          cols[$];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_pal[i] = '0;
    m_sh_x = 0; m_sh_y = 0; m_sh_en = 0;
    m_lv_x = 0; m_lv_y = 0; m_lv_en = 0;
  endtask

  task automatic report_fail(input string what, input logic [13:0] got, input logic [13:0] exp);
    n_err++;
    if (n_print < 50) begin
      n_print++;
      $display("FAIL %s: got hs=%b vs=%b rgb=%h, expected hs=%b vs=%b rgb=%h (vector %0d)",
               what, got[13], got[12], got[11:0], exp[13], exp[12], exp[11:0], n_vec);
    end
  endtask

  // Track which DUT output cycles correspond to a driven pixel
  always @(posedge clkPixel or posedge reset) begin
    if (reset) begin
      iss_d1 <= 1'b0;
      iss_d2 <= 1'b0;
    end else begin
      iss_d1 <= issued;
      iss_d2 <= iss_d1;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clkPixel) begin
    if (iss_d2 && !reset) begin
      mon_got = {hsyncOut, vsyncOut, red, green, blue};
      n_vec++;
      if (exp_q.size() == 0) begin
        report_fail("pixel_out_unexpected", mon_got, 14'h0);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) report_fail("pixel_out", mon_got, mon_exp);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive_cycle(input int h, input int v,
                             input logic we, input logic [8:0] wa, input logic [11:0] wd,
                             input logic pw, input int px, input int py, input logic pe);
    logic        act, hs, vs, hit;
    logic [3:0]  idx;
    logic [11:0] bg, e_rgb;
    @(posedge clkPixel);
    #1;
    act = (h < 640) && (v < 480);
    hs  = !((h >= 656) && (h < 752));
    vs  = !((v == 490) || (v == 491));
    bg  = 12'($urandom_range(0, 4095));
    hPos = 10'(h); vPos = 10'(v);
    videoActive = act; hsyncIn = hs; vsyncIn = vs;
    {redIn, greenIn, blueIn} = bg;
    wrEn = we; wrAddr = wa; wrData = wd;
    posWr = pw; posX = 10'(px); posY = 10'(py); spriteEn = pe;
    // Pixel decision uses the live position and bitmap as they stand before this edge
    hit = act && m_lv_en && (h >= m_lv_x) && (h < m_lv_x + 16) &&
          (v >= m_lv_y) && (v < m_lv_y + 16);
    idx = hit ? m_bmp[(v - m_lv_y) * 16 + (h - m_lv_x)] : 4'd0;
    // Effects of this edge
    if (we && !wa[8]) m_bmp[wa[7:0]] = wd[3:0];
    if (we && wa[8])  m_pal[wa[3:0]] = wd;
    if (pw) begin m_sh_x = px; m_sh_y = py; m_sh_en = pe; end
    if (v == 480 && h == 0) begin m_lv_x = m_sh_x; m_lv_y = m_sh_y; m_lv_en = m_sh_en; end
    // Palette lookup happens one edge later, so this edge's palette write counts
    if (!act)                    e_rgb = 12'h000;
    else if (hit && idx != 4'd0) e_rgb = m_pal[idx];
    else                         e_rgb = bg;
    exp_q.push_back({hs, vs, e_rgb});
    issued = 1'b1;
  endtask

  task automatic do_reset(input int hold);
    @(posedge clkPixel);
    @(negedge clkPixel);
    #1;
    reset = 1'b1;
    wrEn = 1'b0; posWr = 1'b0; issued = 1'b0;
    #1;
    n_vec++;
    if ({red, green, blue} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_rgb: got %h, expected 000", {red, green, blue});
    end
    n_vec++;
    if ({hsyncOut, vsyncOut} !== {SYNC_IDLE, SYNC_IDLE}) begin
      n_err++;
      $display("FAIL reset_sync: got %b%b, expected %b%b", hsyncOut, vsyncOut, SYNC_IDLE, SYNC_IDLE);
    end
    exp_q.delete();
    model_reset();
    repeat (hold) @(posedge clkPixel);
    @(negedge clkPixel);
    reset = 1'b0;
  endtask

  task automatic run_frame(input int f);
    logic        we, pw, pe;
    logic [8:0]  wa;
    logic [11:0] wd;
    int          px, py;
    int          xs[6];
    int          ys[6];
    xs = '{96, 100, 200, 630, 0, 5};
    ys = '{48, 50, 100, 470, 478, 524};
    foreach (lines[li]) begin
      foreach (cols[ci]) begin
        int v, h;
        v = lines[li]; h = cols[ci];
        we = 1'b0; wa = '0; wd = '0; pw = 1'b0; px = 0; py = 0; pe = 1'b0;
        // Directed position updates for the tear-free, clip and blanking frames
        if (f == 1 && v == 48  && h == 0) begin pw = 1; px = 200; py = 100; pe = 1; end
        if (f == 2 && v == 100 && h == 0) begin pw = 1; px = 100; py = 100; pe = 1; end
        if (f == 2 && v == 480 && h == 0) begin pw = 1; px = 630; py = 50;  pe = 1; end
        if (f == 3 && v == 470 && h == 0) begin pw = 1; px = 96;  py = 478; pe = 1; end
        if (f == 4 && v == 1   && h == 0) begin pw = 1; px = 100; py = 50;  pe = 1; end
        if (f == 6 && v == 98  && h == 0) begin pw = 1; px = 100; py = 100; pe = 1; end
        // Random table traffic and occasional position writes
        if (f >= 5) begin
          if ($urandom_range(0, 11) == 0) begin
            we = 1'b1;
            wd = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) == 0) wa = {1'b1, 4'b0000, 4'($urandom_range(0, 15))};
            else                           wa = {1'b0, 8'($urandom_range(0, 255))};
          end
          if (!pw && (($urandom_range(0, 399) == 0) || (f == 5 && v == 480 && h == 0))) begin
            pw = 1'b1;
            px = xs[$urandom_range(0, 5)];
            py = ys[$urandom_range(0, 5)];
            pe = 1'($urandom_range(0, 3) != 0);
          end
        end
        if (f == 6 && v == 50 && h == 100) do_reset(2);
        drive_cycle(h, v, we, wa, wd, pw, px, py, pe);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) m_bmp[i] = '0;
    model_reset();
    lines = '{0, 1, 490, 491, 524};
    for (int v = 48;  v <= 67;  v++) lines.push_back(v);
    for (int v = 98;  v <= 118; v++) lines.push_back(v);
    for (int v = 470; v <= 483; v++) lines.push_back(v);
    lines.sort();
    cols = '{0, 1, 2, 3, 656, 657, 658, 659, 798, 799};
    for (int h = 96;  h <= 120; h++) cols.push_back(h);
    for (int h = 196; h <= 220; h++) cols.push_back(h);
    for (int h = 625; h <= 643; h++) cols.push_back(h);
    cols.sort();

    do_reset(3);

    // Table setup during blanking: bitmap all 1 except {row3,col5}=0
    for (int i = 0; i < 256; i++)
      drive_cycle(700, 500, 1'b1, {1'b0, 8'(i)}, (i == 8'h35) ? 12'h000 : 12'h001, 1'b0, 0, 0, 1'b0);
    drive_cycle(700, 500, 1'b1, 9'h100, 12'hFFF, 1'b0, 0, 0, 1'b0);
    drive_cycle(700, 500, 1'b1, 9'h101, 12'hF00, 1'b0, 0, 0, 1'b0);
    for (int i = 2; i < 16; i++)
      drive_cycle(700, 500, 1'b1, {1'b1, 4'b0000, 4'(i)}, 12'($urandom_range(0, 4095)), 1'b0, 0, 0, 1'b0);
    drive_cycle(700, 500, 1'b0, 9'h000, 12'h000, 1'b1, 100, 50, 1'b1);

    for (int f = 0; f < 8; f++) run_frame(f);

    drive_cycle(700, 500, 1'b0, 9'h000, 12'h000, 1'b0, 0, 0, 1'b0);
    @(posedge clkPixel);
    #1;
    issued = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clkPixel);
    @(negedge clkPixel);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected pixels never presented, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
